mic_adc_capture: RTL and testbench
==================================

Name: mic_adc_capture

Overview:
Serial capture front end for the microphone ADC (ADCS7476-class, 16-bit frame, 12-bit data). It generates the sample-rate tick, chip select and serial clock, and shifts in one frame per tick. It presents a 12-bit sample with a one-cycle valid strobe to the downstream delay/echo stage. It is the stage directly upstream of the audio delay line.

Parameters:
SAMPLE_PERIOD, 5000, CLOCK cycles between conversion starts (20 kHz at 100 MHz); legal range 2..65535.
SCLK_HALF, 5, CLOCK cycles per serial-clock half period (10 MHz at 100 MHz); legal range 1..255.

Ports:
CLOCK  input  1  system clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
miso  input  1  ADC serial data, MSB first
cs_n  output  1  ADC chip select, active low
sclk  output  1  ADC serial clock, idles high
sample  output  12  last completed sample, unsigned
sample_valid  output  1  one-cycle pulse when sample updates
busy  output  1  high while cs_n is low
overrun  output  1  sticky; set when a tick arrives while busy

Behaviour:
- Reset (RESET=1 at a posedge) acts on that edge, including mid-frame. Outputs: cs_n=1, sclk=1, sample=0, sample_valid=0, busy=0, overrun=0. Period counter, half counter, bit counter and shift register all clear to 0. The state machine returns to IDLE.
- Period counter:
  - free-running 0..SAMPLE_PERIOD-1, wraps to 0;
  - tick is asserted when count==SAMPLE_PERIOD-1;
  - the first tick after reset release is at cycle SAMPLE_PERIOD-1, where cycle 0 is the first edge with RESET=0.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: cs_n=1, sclk=1. On tick, go to LOW next cycle with cs_n=0, sclk=0, bit counter=0, half counter=0.
- LOW: sclk=0. Hold for SCLK_HALF cycles. On the last of these cycles, go to HIGH. On the edge where sclk goes 0->1, shift miso into the LSB of the 16-bit shift register.
- HIGH: sclk=1. Hold for SCLK_HALF cycles.
  - Last cycle, bit counter < 15: increment the bit counter and go to LOW.
  - Last cycle, bit counter == 15: go to DONE.
- DONE (single cycle): cs_n=1, sclk=1, sample <= shift[11:0], sample_valid=1. Next state is IDLE. The 4 leading frame bits (shift[15:12]) are discarded regardless of value.
- Frame timing: exactly 16 sclk rising edges per cs_n-low window. cs_n is low for 32*SCLK_HALF cycles. sample_valid occurs 32*SCLK_HALF+1 cycles after the cs_n falling edge (161 at defaults).
- busy = (state != IDLE && state != DONE), i.e. equal to ~cs_n.
- sample holds its value between valids. sample_valid is never high on two consecutive cycles.
- Tick while busy, or tick in DONE (possible when SAMPLE_PERIOD < 32*SCLK_HALF+2): the tick is dropped, overrun is set, and the current frame completes unaffected. overrun clears only on RESET.
- miso is sampled directly, with no synchronizer: the ADC is timed by our own sclk.
- Arithmetic: counters are sized with $clog2 of their parameter and wrap only at the stated limits. There is no signed arithmetic; sample is raw unsigned offset-binary.

Decomposition:
- Shared package/header holds:
  - FSM state encoding localparams;
  - ADC_FRAME_BITS=16;
  - ADC_DATA_BITS=12 (the audio sample width shared with the delay and mixer stages).
- One natural sub-module, sample_rate_tick: the period counter plus tick output, parameterised by SAMPLE_PERIOD. The same module is reused to drive the DAC side.
- The serial shifter and FSM stay in this module.

Test Plan:
- Reset: hold RESET 3 cycles, then release -> cs_n=1, sclk=1, sample=12'h000, sample_valid=0, overrun=0. First cs_n fall at cycle SAMPLE_PERIOD after release.
- Frame decode: ADC model drives 16'h0ABC MSB-first, changing on sclk falling edges -> sample=12'hABC. One valid pulse 161 cycles after cs_n falls. Exactly 16 sclk rising edges counted.
- Header discard: model drives 16'hF123 -> sample=12'h123, no other effect.
- Periodicity: 3 frames 16'h0001, 16'h0FFF, 16'h0800 -> samples 001, FFF, 800. Valids are exactly 5000 cycles apart; sample is stable between valids.
- Reset mid-frame: assert RESET after the 7th sclk rising edge -> cs_n=1, sclk=1 next edge, no valid pulse, sample=0. The next frame after release decodes 16'h0555 -> 12'h555.
- Overrun: SAMPLE_PERIOD=100, SCLK_HALF=5 -> overrun goes 1 at the first tick during a frame. Every frame still has 16 sclk edges. Frames start every 200 cycles (alternate ticks dropped).

Source files
------------

// File: rtl/mic_adc_capture_pkg.sv
// Shared definitions for the microphone ADC capture front end.
package mic_adc_capture_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned ADC_BIT_CNT_W  = $clog2(ADC_FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } adc_state_e;

endpackage

// File: rtl/mic_adc_capture_sample_rate_tick.sv
// Free-running period counter producing a one-cycle tick every PERIOD cycles.
module sample_rate_tick #(
  parameter int unsigned PERIOD = 5000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count wraps at LAST; tick is high while the count sits at LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  // Counter and registered tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/mic_adc_capture.sv
// Serial capture of one 16-bit ADC frame per sample tick; presents 12-bit samples.
module mic_adc_capture
  import mic_adc_capture_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 5000,
  parameter int unsigned SCLK_HALF     = 5
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     miso,
  output logic                     cs_n,
  output logic                     sclk,
  output logic [ADC_DATA_BITS-1:0] sample,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HALF_W-1:0]        HALF_LAST = HALF_W'(SCLK_HALF - 1);
  localparam logic [ADC_BIT_CNT_W-1:0] BIT_LAST  = ADC_BIT_CNT_W'(ADC_FRAME_BITS - 1);

  adc_state_e                state_q, state_d;
  logic [HALF_W-1:0]         half_q, half_d;
  logic [ADC_BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic                      cs_n_q, cs_n_d;
  logic                      sclk_q, sclk_d;
  logic [ADC_DATA_BITS-1:0]  sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic                      tick;
  logic                      half_last;
  logic [ADC_FRAME_BITS-ADC_DATA_BITS-1:0] hdr_unused;

  sample_rate_tick #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .tick_o (tick)
  );

  assign half_last  = (half_q == HALF_LAST);
  // Leading frame bits carry no data and are dropped.
  assign hdr_unused = shift_q[ADC_FRAME_BITS-1:ADC_DATA_BITS];

  // Frame sequencing: sclk half-period timing, bit shifting and sample hand-off.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        busy_d = 1'b0;
        if (tick) begin
          state_d = ST_LOW;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          half_d  = '0;
          bit_d   = '0;
        end
      end
      ST_LOW: begin
        if (half_last) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          half_d  = '0;
          shift_d = {shift_q[ADC_FRAME_BITS-2:0], miso};
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end
      ST_HIGH: begin
        if (half_last) begin
          half_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_LOW;
            sclk_d  = 1'b0;
            bit_d   = bit_q + ADC_BIT_CNT_W'(1);
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        sample_d = shift_q[ADC_DATA_BITS-1:0];
        valid_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A tick that cannot start a frame is dropped and flagged.
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mic_adc_capture.sv
// Bench for mic_adc_capture: default-rate instance plus a fast-tick instance for overrun.
module tb_mic_adc_capture;

  localparam int unsigned SP_A = 5000;
  localparam int unsigned SH_A = 5;
  localparam int unsigned SP_B = 100;
  localparam int unsigned SH_B = 5;
  localparam int unsigned LAT  = 32 * SH_A + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default rates.
  logic RESET_a = 1'b1;
  logic miso_a = 1'b0;
  logic cs_n_a, sclk_a, sample_valid_a, busy_a, overrun_a;
  logic [11:0] sample_a;

  // Instance B: sample period shorter than a frame.
  logic RESET_b = 1'b1;
  logic miso_b = 1'b0;
  logic cs_n_b, sclk_b, sample_valid_b, busy_b, overrun_b;
  logic [11:0] sample_b;

  mic_adc_capture #(.SAMPLE_PERIOD(SP_A), .SCLK_HALF(SH_A)) dut_a (
    .CLOCK(clk), .RESET(RESET_a), .miso(miso_a), .cs_n(cs_n_a), .sclk(sclk_a),
    .sample(sample_a), .sample_valid(sample_valid_a), .busy(busy_a), .overrun(overrun_a));

  mic_adc_capture #(.SAMPLE_PERIOD(SP_B), .SCLK_HALF(SH_B)) dut_b (
    .CLOCK(clk), .RESET(RESET_b), .miso(miso_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .sample(sample_b), .sample_valid(sample_valid_b), .busy(busy_b), .overrun(overrun_b));

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic rst_edge_a = 1'b1;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rst_edge_a <= RESET_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ADC model A: MSB on cs_n fall, next bit on each sclk fall; also frame statistics.
  logic [15:0] word_a = 16'h0000;
  int idx_a = 15, rises_a = 0, last_rises_a = 0, fall_cyc_a = 0, valid_cnt_a = 0;
  int consec_err = 0, stable_err = 0, busy_err = 0;
  logic cs_prev_a = 1'b1, sclk_prev_a = 1'b1, valid_prev_a = 1'b0;
  logic [11:0] prev_sample_a = 12'h000;

  always @(negedge clk) begin
    if (!cs_n_a && cs_prev_a) begin
      idx_a = 15; miso_a = word_a[15]; rises_a = 0; fall_cyc_a = cyc;
    end else if (!cs_n_a && sclk_prev_a && !sclk_a) begin
      idx_a = idx_a - 1; miso_a = word_a[idx_a];
    end
    if (!cs_n_a && !sclk_prev_a && sclk_a) rises_a++;
    if (cs_n_a && !cs_prev_a) last_rises_a = rises_a;
    if (sample_valid_a) valid_cnt_a++;
    if (sample_valid_a && valid_prev_a) consec_err++;
    if (busy_a !== ~cs_n_a) busy_err++;
    if (!rst_edge_a && !sample_valid_a && sample_a !== prev_sample_a) stable_err++;
    cs_prev_a = cs_n_a; sclk_prev_a = sclk_a; valid_prev_a = sample_valid_a;
    prev_sample_a = sample_a;
  end

  // ADC model B: same protocol; records sclk rising edges per completed frame.
  localparam logic [15:0] WORD_B = 16'h0A5C;
  int idx_b = 15, rises_b = 0;
  int rises_q_b[$];
  logic cs_prev_b = 1'b1, sclk_prev_b = 1'b1;

  always @(negedge clk) begin
    if (!cs_n_b && cs_prev_b) begin
      idx_b = 15; miso_b = WORD_B[15]; rises_b = 0;
    end else if (!cs_n_b && sclk_prev_b && !sclk_b) begin
      idx_b = idx_b - 1; miso_b = WORD_B[idx_b];
    end
    if (!cs_n_b && !sclk_prev_b && sclk_b) rises_b++;
    if (cs_n_b && !cs_prev_b) rises_q_b.push_back(rises_b);
    cs_prev_b = cs_n_b; sclk_prev_b = sclk_b;
  end

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < int'(SP_A) + 200; k++) begin
      @(posedge clk); #1;
      if (sample_valid_a) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit ok;
    int k, prev_valid_cyc, vc, ovr_k, nvb;
    int falls[$];
    logic csb_prev;
    logic [15:0] w;
    logic [11:0] e;

    tbl[0] = '{16'h0ABC, 12'hABC};
    tbl[1] = '{16'hF123, 12'h123};
    tbl[2] = '{16'h0001, 12'h001};
    tbl[3] = '{16'h0FFF, 12'hFFF};
    tbl[4] = '{16'h0800, 12'h800};

    // Reset held three cycles, then released.
    word_a = tbl[0].word;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd1);
    check("rst_sample", 32'(sample_a), 32'h000);
    check("rst_valid", 32'(sample_valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    RESET_a = 1'b0;

    // First chip-select fall comes SAMPLE_PERIOD edges after release.
    k = 0;
    for (int n = 1; n <= int'(SP_A) + 20; n++) begin
      @(posedge clk); #1;
      if (!cs_n_a) begin k = n; break; end
    end
    check("first_cs_fall", 32'(k), 32'(SP_A));

    // Directed frames from the table.
    prev_valid_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      word_a = tbl[i].word;
      wait_valid_a(ok);
      check("valid_seen", 32'(ok), 32'd1);
      check("tbl_sample", 32'(sample_a), 32'(tbl[i].exp));
      check("tbl_latency", 32'(cyc - fall_cyc_a), 32'(LAT));
      check("tbl_rises", 32'(last_rises_a), 32'd16);
      if (i > 0) check("tbl_spacing", 32'(cyc - prev_valid_cyc), 32'(SP_A));
      prev_valid_cyc = cyc;
    end

    // Random frames: expected sample is the low data bits of the frame.
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      e = w[11:0];
      word_a = w;
      wait_valid_a(ok);
      check("rnd_valid_seen", 32'(ok), 32'd1);
      check("rnd_sample", 32'(sample_a), 32'(e));
      check("rnd_rises", 32'(last_rises_a), 32'd16);
      check("rnd_spacing", 32'(cyc - prev_valid_cyc), 32'(SP_A));
      prev_valid_cyc = cyc;
    end

    // Reset mid-frame after the 7th sclk rising edge.
    word_a = 16'h0777;
    ok = 1'b0;
    for (int n = 0; n < int'(SP_A) + 20; n++) begin
      @(posedge clk); #1;
      if (!cs_n_a) begin ok = 1'b1; break; end
    end
    check("mid_cs_fall_seen", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (rises_a >= 7) begin ok = 1'b1; break; end
    end
    check("mid_rise7_seen", 32'(ok), 32'd1);
    vc = valid_cnt_a;
    RESET_a = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cs_n", 32'(cs_n_a), 32'd1);
    check("mid_rst_sclk", 32'(sclk_a), 32'd1);
    check("mid_rst_sample", 32'(sample_a), 32'h000);
    check("mid_rst_valid", 32'(sample_valid_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_no_valid", 32'(valid_cnt_a), 32'(vc));
    word_a = 16'h0555;
    RESET_a = 1'b0;
    k = 0;
    for (int n = 1; n <= int'(SP_A) + 400; n++) begin
      @(posedge clk); #1;
      if (sample_valid_a) begin k = n; break; end
    end
    check("mid_next_valid_at", 32'(k), 32'(SP_A + LAT));
    check("mid_next_sample", 32'(sample_a), 32'h555);
    check("mid_next_rises", 32'(last_rises_a), 32'd16);

    // Overrun: period shorter than a frame drops alternate ticks.
    RESET_b = 1'b0;
    ovr_k = 0; nvb = 0; csb_prev = 1'b1;
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (overrun_b && ovr_k == 0) ovr_k = n;
      if (!cs_n_b && csb_prev) falls.push_back(n);
      csb_prev = cs_n_b;
      if (sample_valid_b) begin
        check("b_sample", 32'(sample_b), 32'hA5C);
        nvb++;
      end
    end
    check("b_overrun_at", 32'(ovr_k), 32'(2 * SP_B));
    check("b_overrun_sticky", 32'(overrun_b), 32'd1);
    check("b_frame_count", 32'(falls.size()), 32'd4);
    for (int i = 0; i < falls.size(); i++)
      check("b_frame_start", 32'(falls[i]), 32'(SP_B + i * 2 * SP_B));
    check("b_valid_count", 32'(nvb), 32'd3);
    check("b_done_frames", 32'(rises_q_b.size()), 32'd3);
    foreach (rises_q_b[i]) check("b_rises", 32'(rises_q_b[i]), 32'd16);

    // Whole-run invariants of instance A.
    check("a_no_overrun", 32'(overrun_a), 32'd0);
    check("a_valid_single_cycle", 32'(consec_err), 32'd0);
    check("a_sample_stable", 32'(stable_err), 32'd0);
    check("a_busy_eq_not_cs", 32'(busy_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
